// File: rtl/stack_exec_ctrl_if.sv
// Bundle between the stack CPU execution controller and its surroundings.
//   Nibble stream : in_valid, in_nibble (to controller), in_ready (from controller)
//   Datapath taps : v0, v1 (stack top / next), ram_rdata (registered RAM read data)
//   Stack control : stack_accept (push), stack_pop, push_data
//   RAM control   : ram_addr, ram_write
//   Status        : depth, fault, halted
// master = the side feeding nibbles and datapath values; slave = the controller.
interface stack_exec_ctrl_if;
  logic       in_valid;
  logic [3:0] in_nibble;
  logic       in_ready;
  logic [3:0] v0;
  logic [3:0] v1;
  logic [3:0] ram_rdata;
  logic       stack_accept;
  logic       stack_pop;
  logic [3:0] push_data;
  logic [3:0] ram_addr;
  logic       ram_write;
  logic [3:0] depth;
  logic       fault;
  logic       halted;

  modport master (
    output in_valid, in_nibble, v0, v1, ram_rdata,
    input  in_ready, stack_accept, stack_pop, push_data, ram_addr, ram_write, depth, fault,
           halted
  );

  modport slave (
    input  in_valid, in_nibble, v0, v1, ram_rdata,
    output in_ready, stack_accept, stack_pop, push_data, ram_addr, ram_write, depth, fault,
           halted
  );
endinterface

// File: rtl/stack_exec_ctrl.sv
// Execution controller for the 4-bit stack CPU.
// Accepts opcode/operand nibbles over a valid/ready handshake, then sequences one datapath
// action per cycle: push/pop strobes to the stack register and address/write to the 16x4 RAM.
// Tracks stack occupancy to reject overflow/underflow and flags faults and HALT.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - stack_exec_ctrl_if.slave (handshake, datapath taps, strobes, status)
// Parameter DEPTH: stack register depth in entries (2..15).
module stack_exec_ctrl #(
  parameter int unsigned DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  stack_exec_ctrl_if.slave bus
);

  localparam logic [3:0] DepthMax = 4'(DEPTH);

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpPush  = 4'd1;
  localparam logic [3:0] OpPop   = 4'd2;
  localparam logic [3:0] OpDup   = 4'd3;
  localparam logic [3:0] OpAdd   = 4'd4;
  localparam logic [3:0] OpLoad  = 4'd5;
  localparam logic [3:0] OpStore = 4'd6;
  localparam logic [3:0] OpHalt  = 4'd7;

  typedef enum logic [3:0] {
    StFetch, StOpnd, StPush, StPop, StAddP1, StAddP2, StAddPush,
    StLdRd, StLdPush, StStWr, StStPop, StHalt
  } state_e;

  state_e     state_q;
  logic [3:0] op_q;
  logic [3:0] sum_q;
  logic [3:0] push_data_q;
  logic [3:0] ram_addr_q;
  logic [3:0] depth_q;
  logic       in_ready_q;
  logic       accept_q;
  logic       pop_q;
  logic       ram_write_q;
  logic       fault_q;
  logic       halted_q;
  logic       xfer;

  assign xfer = bus.in_valid & in_ready_q;

  // Strobes are registered alongside the state, so each equals "currently in a strobing state".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      op_q        <= '0;
      sum_q       <= '0;
      push_data_q <= '0;
      ram_addr_q  <= '0;
      depth_q     <= '0;
      in_ready_q  <= 1'b1;
      accept_q    <= 1'b0;
      pop_q       <= 1'b0;
      ram_write_q <= 1'b0;
      fault_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      accept_q    <= 1'b0;
      pop_q       <= 1'b0;
      ram_write_q <= 1'b0;

      // Depth follows the strobe of the cycle just ending; guards keep it in 0..DEPTH.
      if (accept_q) begin
        depth_q <= depth_q + 4'd1;
      end else if (pop_q) begin
        depth_q <= depth_q - 4'd1;
      end

      unique case (state_q)
        StFetch: begin
          if (xfer) begin
            op_q <= bus.in_nibble;
            case (bus.in_nibble)
              OpNop: ;
              OpPush, OpLoad, OpStore: state_q <= StOpnd;
              OpPop: begin
                if (depth_q == 4'd0) begin
                  fault_q <= 1'b1;
                end else begin
                  state_q    <= StPop;
                  pop_q      <= 1'b1;
                  in_ready_q <= 1'b0;
                end
              end
              OpDup: begin
                if (depth_q == 4'd0 || depth_q == DepthMax) begin
                  fault_q <= 1'b1;
                end else begin
                  state_q     <= StPush;
                  accept_q    <= 1'b1;
                  push_data_q <= bus.v0;
                  in_ready_q  <= 1'b0;
                end
              end
              OpAdd: begin
                if (depth_q < 4'd2) begin
                  fault_q <= 1'b1;
                end else begin
                  // Capture the sum now; both operands are gone after the two pops.
                  sum_q      <= bus.v0 + bus.v1;
                  state_q    <= StAddP1;
                  pop_q      <= 1'b1;
                  in_ready_q <= 1'b0;
                end
              end
              OpHalt: begin
                state_q    <= StHalt;
                halted_q   <= 1'b1;
                in_ready_q <= 1'b0;
              end
              default: fault_q <= 1'b1;
            endcase
          end
        end

        StOpnd: begin
          if (xfer) begin
            case (op_q)
              OpPush: begin
                if (depth_q == DepthMax) begin
                  fault_q <= 1'b1;
                  state_q <= StFetch;
                end else begin
                  state_q     <= StPush;
                  accept_q    <= 1'b1;
                  push_data_q <= bus.in_nibble;
                  in_ready_q  <= 1'b0;
                end
              end
              OpLoad: begin
                if (depth_q == DepthMax) begin
                  fault_q <= 1'b1;
                  state_q <= StFetch;
                end else begin
                  ram_addr_q <= bus.in_nibble;
                  state_q    <= StLdRd;
                  in_ready_q <= 1'b0;
                end
              end
              OpStore: begin
                if (depth_q == 4'd0) begin
                  fault_q <= 1'b1;
                  state_q <= StFetch;
                end else begin
                  ram_addr_q  <= bus.in_nibble;
                  state_q     <= StStWr;
                  ram_write_q <= 1'b1;
                  in_ready_q  <= 1'b0;
                end
              end
              default: state_q <= StFetch;
            endcase
          end
        end

        StPush, StPop, StAddPush, StStPop: begin
          state_q    <= StFetch;
          in_ready_q <= 1'b1;
        end

        StAddP1: begin
          state_q <= StAddP2;
          pop_q   <= 1'b1;
        end

        StAddP2: begin
          state_q     <= StAddPush;
          accept_q    <= 1'b1;
          push_data_q <= sum_q;
        end

        StLdRd: begin
          state_q  <= StLdPush;
          accept_q <= 1'b1;
        end

        StLdPush: begin
          // Keep the loaded value on push_data once LD_PUSH is over.
          push_data_q <= bus.ram_rdata;
          state_q     <= StFetch;
          in_ready_q  <= 1'b1;
        end

        StStWr: begin
          state_q <= StStPop;
          pop_q   <= 1'b1;
        end

        StHalt: ;

        default: begin
          state_q    <= StFetch;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q & ~rst;
  assign bus.stack_accept = accept_q;
  assign bus.stack_pop    = pop_q;
  // RAM read data is only valid during LD_PUSH, so it bypasses the register there.
  assign bus.push_data    = (state_q == StLdPush) ? bus.ram_rdata : push_data_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_write    = ram_write_q;
  assign bus.depth        = depth_q;
  assign bus.fault        = fault_q;
  assign bus.halted       = halted_q;

endmodule
